// File: rtl/dcache1_wb_queue_if.sv
// Bus bundle between the dcache1 tag ways / L2 writeback port and the victim writeback queue.
// The queue side uses the slave modport; the cache/L2 environment uses master.
interface dcache1_wb_queue_if #(
    parameter int WB_WIDTH = 37,
    parameter int DEPTH    = 4
);
    logic                       wb_en;
    logic [WB_WIDTH-1:0]        wb_addr;
    logic                       wb_valid;
    logic                       wb_stall;
    logic                       out_req;
    logic [WB_WIDTH-1:0]        out_addr;
    logic                       out_ack;
    logic [WB_WIDTH-1:0]        lookup_addr;
    logic                       lookup_hit;
    logic [$clog2(DEPTH):0]     wb_count;
    logic                       wb_overflow;

    // out_req/out_ack: a request is presented while out_req is high and out_addr
    // holds still; it completes on the first active edge that sees out_ack high.
    modport master (
        output wb_en, wb_addr, wb_valid, out_ack, lookup_addr,
        input  wb_stall, out_req, out_addr, lookup_hit, wb_count, wb_overflow
    );

    modport slave (
        input  wb_en, wb_addr, wb_valid, out_ack, lookup_addr,
        output wb_stall, out_req, out_addr, lookup_hit, wb_count, wb_overflow
    );
endinterface

// File: rtl/dcache1_wb_queue.sv
// In-order victim writeback queue: merges duplicate victims, issues one L2 request at a
// time and reports whether a probed line is still awaiting writeback.
module dcache1_wb_queue #(
    parameter int PADDR_WIDTH = 44,
    parameter int WB_WIDTH    = PADDR_WIDTH - 7,
    parameter int DEPTH       = 4
) (
    input logic              clk,
    input logic              rst,
    dcache1_wb_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [WB_WIDTH-1:0] addr_q [DEPTH];
    logic [DEPTH-1:0]    vld_q;
    logic [PW-1:0]       head_q;
    logic [PW-1:0]       tail_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_next;
    logic [0:0]          state_q;
    logic                overflow_q;

    logic victim;
    logic pop;
    logic dup;
    logic push;
    logic full;
    logic entry_hit;

    always_comb begin
        victim    = bus.wb_en & bus.wb_valid;
        pop       = (state_q == SEND) && bus.out_ack && (count_q != '0);
        full      = (count_q == CW'(DEPTH));
        dup       = 1'b0;
        entry_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            // The entry leaving this edge no longer holds the line, so a re-eviction must requeue it.
            if (vld_q[i] && (addr_q[i] == bus.wb_addr) && !(pop && (PW'(i) == head_q)))
                dup = 1'b1;
            if (vld_q[i] && (addr_q[i] == bus.lookup_addr))
                entry_hit = 1'b1;
        end
        push       = victim && !dup && (!full || pop);
        count_next = count_q + CW'(push) - CW'(pop);
    end

    // All state follows the tag pipeline, which updates on the falling edge.
    always_ff @(negedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PW'(1);
            end
            if (push) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + PW'(1);
            end
            if (victim && !dup && full && !pop)
                overflow_q <= 1'b1;
            count_q <= count_next;
            case (state_q)
                IDLE:    if (count_q != '0) state_q <= SEND;
                SEND:    if (pop && (count_next == '0)) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (push)
            addr_q[tail_q] <= bus.wb_addr;
    end

    assign bus.wb_stall    = (count_q >= CW'(DEPTH - 1));
    assign bus.out_req     = (state_q == SEND);
    assign bus.out_addr    = (state_q == SEND) ? addr_q[head_q] : '0;
    assign bus.lookup_hit  = (entry_hit & ~rst) | (victim & (bus.wb_addr == bus.lookup_addr));
    assign bus.wb_count    = count_q;
    assign bus.wb_overflow = overflow_q;
endmodule

// File: tb/tb_dcache1_wb_queue.sv
// Directed and randomized bench for dcache1_wb_queue against a queue-based reference model.
module tb_dcache1_wb_queue;
    localparam int W     = 37;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [W-1:0] exp_q[$];
    bit           m_send;
    bit           m_ovf;
    logic [W-1:0] pool [6];

    dcache1_wb_queue_if #(.WB_WIDTH(W), .DEPTH(DEPTH)) bus ();

    dcache1_wb_queue #(.PADDR_WIDTH(44), .WB_WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_q(input logic [W-1:0] a);
        for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    // One cycle: drive mid-cycle, check just after, model the falling edge that follows.
    task automatic step(input logic en, input logic valid, input logic [W-1:0] a,
                        input logic ack, input logic [W-1:0] lk, input logic r);
        bit was_nonempty;
        bit exp_hit;
        @(posedge clk);
        rst             = r;
        bus.wb_en       = en;
        bus.wb_valid    = valid;
        bus.wb_addr     = a;
        bus.out_ack     = ack;
        bus.lookup_addr = lk;
        #1;
        chk("out_req", 64'(bus.out_req), 64'(m_send));
        if (m_send) chk("out_addr", 64'(bus.out_addr), 64'(exp_q[0]));
        else        chk("out_addr", 64'(bus.out_addr), 64'd0);
        chk("wb_count", 64'(bus.wb_count), 64'(exp_q.size()));
        chk("wb_stall", 64'(bus.wb_stall), 64'(exp_q.size() >= DEPTH - 1));
        chk("wb_overflow", 64'(bus.wb_overflow), 64'(m_ovf));
        exp_hit = (en && valid && (a == lk)) || (!r && in_q(lk));
        chk("lookup_hit", 64'(bus.lookup_hit), 64'(exp_hit));
        if (r) begin
            exp_q.delete();
            m_send = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            was_nonempty = (exp_q.size() != 0);
            if (m_send && ack) void'(exp_q.pop_front());
            if (en && valid && !in_q(a)) begin
                if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
                else                       exp_q.push_back(a);
            end
            m_send = m_send ? (exp_q.size() != 0) : was_nonempty;
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [W-1:0] a, input logic ack, input logic [W-1:0] lk);
        step(1'b1, 1'b1, a, ack, lk, 1'b0);
    endtask

    task automatic idle(input logic ack, input logic [W-1:0] lk);
        step(1'b0, 1'b0, '0, ack, lk, 1'b0);
    endtask

    initial begin
        logic [W-1:0] a, b, c, d;
        checks = 0;
        errors = 0;
        a = 37'h0_1234_5671;
        b = 37'h0_1234_5672;
        c = 37'h1_0abc_de03;
        d = 37'h0_dead_bee4;
        pool[0] = a; pool[1] = b; pool[2] = c; pool[3] = d;
        pool[4] = 37'h1_ffff_fff0; pool[5] = 37'h0_0000_0001;
        m_send = 1'b0;
        m_ovf  = 1'b0;

        rst = 1'b1;
        bus.wb_en = 1'b0; bus.wb_valid = 1'b0; bus.wb_addr = '0;
        bus.out_ack = 1'b0; bus.lookup_addr = '0;
        @(negedge clk);
        @(negedge clk);
        step(1'b0, 1'b0, '0, 1'b0, a, 1'b1);

        // Single push, bypass hit, request, ack, hit clears
        push(a, 1'b0, a);
        idle(1'b0, a);
        idle(1'b0, a);
        idle(1'b1, a);
        idle(1'b0, a);

        // Three pushes, stall at 3, drain with ack held
        push(a, 1'b0, b);
        push(b, 1'b0, b);
        push(c, 1'b0, b);
        idle(1'b0, b);
        for (int i = 0; i < 5; i++) idle(1'b1, c);

        // Duplicate merge
        push(a, 1'b0, a);
        push(a, 1'b0, a);
        idle(1'b0, a);
        idle(1'b1, a);
        idle(1'b0, a);

        // Invalid victim ignored
        step(1'b1, 1'b0, b, 1'b0, b, 1'b0);
        idle(1'b0, b);

        // Overflow when full without pop
        push(a, 1'b0, d);
        push(b, 1'b0, d);
        push(c, 1'b0, d);
        push(pool[4], 1'b0, d);
        push(d, 1'b0, d);
        idle(1'b0, d);
        step(1'b0, 1'b0, '0, 1'b0, d, 1'b1);

        // Full plus simultaneous push/pop: accepted, D drains last
        push(a, 1'b0, d);
        push(b, 1'b0, d);
        push(c, 1'b0, d);
        push(pool[4], 1'b0, d);
        push(d, 1'b1, d);
        for (int i = 0; i < 6; i++) idle(1'b1, d);

        // Reset while sending with three entries
        push(a, 1'b0, a);
        push(b, 1'b0, a);
        push(c, 1'b0, a);
        idle(1'b0, a);
        step(1'b0, 1'b0, '0, 1'b0, a, 1'b1);
        idle(1'b1, a);

        // Randomized traffic with a small address pool so merges and hits occur
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 4) != 0),
                 pool[$urandom_range(0, 5)], 1'($urandom_range(0, 2) == 0),
                 pool[$urandom_range(0, 5)], 1'($urandom_range(0, 59) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
